// File: rtl/interrupt_sequencer.sv
// Priority interrupt sequencer: captures sources into pending, presents the highest unmasked one, holds it through ack/eoi.
// Latency: capture at E0 -> pending after E0 -> cpu_irq after E1; one mandatory IDLE cycle after every eoi.
// Backpressure: no nesting, new sources only accumulate in pending until eoi; IRQ_EDGE_DETECT_EN selects edge capture over level.
module interrupt_sequencer #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         irq,
    input  logic [N-1:0]         mask,
    input  logic                 cpu_ack,
    input  logic                 eoi,
    output logic                 cpu_irq,
    output logic [$clog2(N)-1:0] cpu_id,
    output logic                 in_service,
    output logic [N-1:0]         pending
);
    localparam int ID_W = $clog2(N);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t          state;
    logic [N-1:0]    eligible;
    logic [ID_W-1:0] winner;
    logic [N-1:0]    pending_nxt;

    assign eligible = pending & ~mask;

    // Later (higher) indices overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        winner = '0;
        for (int i = 0; i < N; i++) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
    end

`ifdef IRQ_EDGE_DETECT_EN
    logic [N-1:0] irq_q;
    logic [N-1:0] ack_clr;

    always_comb begin
        ack_clr = '0;
        if (state == REQ && cpu_ack) begin
            ack_clr[cpu_id] = 1'b1;
        end
    end

    // A fresh rising edge on the acked bit outranks the clear.
    assign pending_nxt = (pending & ~ack_clr) | (irq & ~irq_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq;
        end
    end
`else
    // Level mode: pending simply mirrors the registered sources, so an ack-clear never sticks.
    assign pending_nxt = irq;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            cpu_id  <= '0;
        end else begin
            pending <= pending_nxt;
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        state  <= REQ;
                        cpu_id <= winner;
                    end
                end
                REQ: begin
                    if (cpu_ack) begin
                        state <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cpu_irq    = (state == REQ);
    assign in_service = (state == SERVICE);

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed vector bench for interrupt_sequencer (N=8), expectations valid for level and edge capture builds.
module tb_interrupt_sequencer;
    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq;
    logic [7:0] mask;
    logic       cpu_ack;
    logic       eoi;
    logic       cpu_irq;
    logic [2:0] cpu_id;
    logic       in_service;
    logic [7:0] pending;

    int n_vec = 0;
    int miscompares = 0;

    interrupt_sequencer #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq        (irq),
        .mask       (mask),
        .cpu_ack    (cpu_ack),
        .eoi        (eoi),
        .cpu_irq    (cpu_irq),
        .cpu_id     (cpu_id),
        .in_service (in_service),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] irq;
        logic [7:0] mask;
        logic       ack;
        logic       eoi;
        logic       e_irq;
        logic [2:0] e_id;
        logic       e_svc;
        logic [7:0] e_pend;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [7:0] i, input logic [7:0] m,
                                input logic a, input logic e, input logic xi,
                                input logic [2:0] xid, input logic xs, input logic [7:0] xp);
        vec_t v;
        v.rst = r; v.irq = i; v.mask = m; v.ack = a; v.eoi = e;
        v.e_irq = xi; v.e_id = xid; v.e_svc = xs; v.e_pend = xp;
        return v;
    endfunction

    task automatic chk(input string tag, input int idx, input string what,
                       input logic [7:0] got, input logic [7:0] exp);
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d] %s got %0h expected %0h", tag, idx, what, got, exp);
        end
    endtask

    // Drive on the falling edge, check the state that the next rising edge produced.
    task automatic apply(input vec_t v, input string tag, input int idx);
        @(negedge clk);
        rst = v.rst; irq = v.irq; mask = v.mask; cpu_ack = v.ack; eoi = v.eoi;
        @(posedge clk);
        #1;
        n_vec++;
        chk(tag, idx, "cpu_irq", {7'd0, cpu_irq}, {7'd0, v.e_irq});
        chk(tag, idx, "cpu_id", {5'd0, cpu_id}, {5'd0, v.e_id});
        chk(tag, idx, "in_service", {7'd0, in_service}, {7'd0, v.e_svc});
        chk(tag, idx, "pending", pending, v.e_pend);
    endtask

    vec_t vq[$];

    initial begin
        rst = 1'b1; irq = '0; mask = '0; cpu_ack = 1'b0; eoi = 1'b0;

        //                  rst irq    mask   ack eoi  cpu_irq id svc pending
        // reset, then quiet
        vq.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00));
        for (int k = 0; k < 5; k++) vq.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00));
        // single source 3: capture, request, ack, eoi
        vq.push_back(mk(0, 8'h08, 8'h00, 0, 0, 0, 0, 0, 8'h08));
        vq.push_back(mk(0, 8'h08, 8'h00, 0, 0, 1, 3, 0, 8'h08));
        vq.push_back(mk(0, 8'h08, 8'h00, 0, 0, 1, 3, 0, 8'h08));
        vq.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 3, 1, 8'h00));
        vq.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 3, 1, 8'h00));
        vq.push_back(mk(0, 8'h00, 8'h00, 0, 1, 0, 3, 0, 8'h00));
        vq.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 3, 0, 8'h00));
        vq.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 3, 0, 8'h00));   // ack in IDLE ignored
        // 6 and 3 together: 6 first, then 3 after one IDLE cycle
        vq.push_back(mk(0, 8'h48, 8'h00, 0, 0, 0, 3, 0, 8'h48));
        vq.push_back(mk(0, 8'h48, 8'h00, 0, 0, 1, 6, 0, 8'h48));
        vq.push_back(mk(0, 8'h08, 8'h00, 1, 0, 0, 6, 1, 8'h08));
        vq.push_back(mk(0, 8'h08, 8'h00, 0, 1, 0, 6, 0, 8'h08));
        vq.push_back(mk(0, 8'h08, 8'h00, 0, 0, 1, 3, 0, 8'h08));
        vq.push_back(mk(0, 8'h08, 8'h00, 0, 1, 1, 3, 0, 8'h08));   // eoi in REQ ignored
        vq.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 3, 1, 8'h00));
        vq.push_back(mk(0, 8'h00, 8'h00, 0, 1, 0, 3, 0, 8'h00));
        // mask 6: 3 dispatches; unmasking in SERVICE does not preempt
        vq.push_back(mk(0, 8'h48, 8'h40, 0, 0, 0, 3, 0, 8'h48));
        vq.push_back(mk(0, 8'h48, 8'h40, 0, 0, 1, 3, 0, 8'h48));
        vq.push_back(mk(0, 8'h40, 8'h40, 1, 0, 0, 3, 1, 8'h40));
        vq.push_back(mk(0, 8'h40, 8'h00, 0, 0, 0, 3, 1, 8'h40));
        vq.push_back(mk(0, 8'h40, 8'h00, 0, 1, 0, 3, 0, 8'h40));
        vq.push_back(mk(0, 8'h40, 8'h00, 0, 0, 1, 6, 0, 8'h40));
        vq.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 6, 1, 8'h00));
        vq.push_back(mk(0, 8'h00, 8'h00, 0, 1, 0, 6, 0, 8'h00));
        // 7 rises while 3 is presented: id holds at 3, 7 goes next
        vq.push_back(mk(0, 8'h08, 8'h00, 0, 0, 0, 6, 0, 8'h08));
        vq.push_back(mk(0, 8'h08, 8'h00, 0, 0, 1, 3, 0, 8'h08));
        vq.push_back(mk(0, 8'h88, 8'h00, 0, 0, 1, 3, 0, 8'h88));
        vq.push_back(mk(0, 8'h88, 8'h00, 0, 0, 1, 3, 0, 8'h88));
        vq.push_back(mk(0, 8'h80, 8'h00, 1, 0, 0, 3, 1, 8'h80));
        vq.push_back(mk(0, 8'h80, 8'h00, 0, 1, 0, 3, 0, 8'h80));
        vq.push_back(mk(0, 8'h80, 8'h00, 0, 0, 1, 7, 0, 8'h80));
        vq.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 7, 1, 8'h00));
        vq.push_back(mk(0, 8'h00, 8'h00, 0, 1, 0, 7, 0, 8'h00));

        for (int k = 0; k < vq.size(); k++) apply(vq[k], "tbl", k);

        // Reset while in SERVICE with source 7 pending; rst overrides ack/eoi.
        apply(mk(0, 8'h01, 8'h00, 0, 0, 0, 7, 0, 8'h01), "rst_svc", 0);
        apply(mk(0, 8'h01, 8'h00, 0, 0, 1, 0, 0, 8'h01), "rst_svc", 1);
        apply(mk(0, 8'h80, 8'h00, 1, 0, 0, 0, 1, 8'h80), "rst_svc", 2);
        apply(mk(1, 8'h80, 8'h00, 1, 1, 0, 0, 0, 8'h00), "rst_svc", 3);
        // irq held at 8'h80 through reset: captured after release against a zero history
        apply(mk(0, 8'h80, 8'h00, 0, 0, 0, 0, 0, 8'h80), "rst_svc", 4);
        apply(mk(0, 8'h80, 8'h00, 0, 0, 1, 7, 0, 8'h80), "rst_svc", 5);
`ifdef IRQ_EDGE_DETECT_EN
        // Held level is captured once: ack clears it for good.
        apply(mk(0, 8'h80, 8'h00, 1, 0, 0, 7, 1, 8'h00), "held", 0);
        apply(mk(0, 8'h80, 8'h00, 0, 1, 0, 7, 0, 8'h00), "held", 1);
        apply(mk(0, 8'h80, 8'h00, 0, 0, 0, 7, 0, 8'h00), "held", 2);
        apply(mk(0, 8'h80, 8'h00, 0, 0, 0, 7, 0, 8'h00), "held", 3);
`else
        // Level source still high: ack-clear does not stick and it re-dispatches after eoi.
        apply(mk(0, 8'h80, 8'h00, 1, 0, 0, 7, 1, 8'h80), "held", 0);
        apply(mk(0, 8'h80, 8'h00, 0, 1, 0, 7, 0, 8'h80), "held", 1);
        apply(mk(0, 8'h80, 8'h00, 0, 0, 1, 7, 0, 8'h80), "held", 2);
        apply(mk(0, 8'h00, 8'h00, 1, 0, 0, 7, 1, 8'h00), "held", 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end
endmodule
